wb_burst_traffic_gen: RTL and testbench
=======================================

// Module: wb_burst_traffic_gen
// PURPOSE
// Parametrised Wishbone B3 bus master. It generates patterned burst write and/or read traffic
// toward the SDRAM controller's Wishbone slave port.
// On reads, it checks returned data against the same pattern and logs mismatches and bus timeouts.
// It sits in place of the software-driven bus master in self-checking SDRAM regressions.
// PARAMETERS
// DW         32    data width; byte lanes = DW/8; address step per beat = DW/8
// AW         26    byte address width
// BL         8     max beats per Wishbone burst (>=1)
// LENW       16    width of transfer length (words)
// TO_CYCLES  1024  cycles stb may stay unacked before timeout abort
// ECW        16    error counter width (saturating)
// PORTS
// wb_clk_i          in   1      system clock
// wb_rst_i          in   1      synchronous active-high reset
// start_i           in   1      1-cycle start pulse; ignored while busy_o=1
// cfg_op_i          in   2      00 write only, 01 read only, 10 write then read, 11 reserved (=10)
// cfg_pat_i         in   2      00 seed+i, 01 ~(seed+i), 10 byte addr zero-ext, 11 seed const
// cfg_base_i        in   AW     start byte address (DW/8-aligned; low bits forced 0)
// cfg_len_i         in   LENW   total words to transfer
// cfg_seed_i        in   DW     pattern seed
// wb_cyc_o          out  1      Wishbone cycle
// wb_stb_o          out  1      Wishbone strobe
// wb_we_o           out  1      1=write
// wb_addr_o         out  AW     byte address
// wb_dat_o          out  DW     write data
// wb_sel_o          out  DW/8   byte enables, all ones during stb
// wb_cti_o          out  3      010 incrementing, 111 last beat
// wb_dat_i          in   DW     read data
// wb_ack_i          in   1      beat acknowledge
// busy_o            out  1      operation in progress
// done_o            out  1      1-cycle pulse at end of operation
// err_o             out  1      sticky: any mismatch or timeout since last start
// timeout_o         out  1      sticky: operation aborted by timeout
// err_cnt_o         out  ECW    read mismatch count, saturates at all ones
// first_err_addr_o  out  AW     byte address of first mismatch (0 if none)
// BEHAVIOUR
// - Reset (sampled on wb_clk_i edge): all outputs 0; FSM->IDLE. This applies mid-burst too:
//   cyc/stb drop at that edge.
// - start_i sampled at edge N with cfg_*: cfg is latched; err_o, timeout_o, err_cnt_o and
//   first_err_addr_o are cleared; busy_o=1 from N+1.
// - FSM: IDLE -> WR (op 00/10) | RD (op 01) | DONE (cfg_len_i=0, no bus activity).
// - WR/RD burst: cyc=stb=1 from N+1; wb_we_o=1 in WR, 0 in RD.
// - Burst beats = min(BL, words remaining). Bursts never straddle a BL-word boundary
//   relative to base.
// - Beat index i counts 0..len-1 across the whole op. Address = base + i*(DW/8), mod 2^AW (wraps).
// - Pattern word i is computed mod 2^DW and must be identical for WR and RD of the same op.
// - cti=010 on all beats except the last beat of each burst, where cti=111.
//   A 1-beat burst is 111 only.
// - On ack edge: advance i, addr, data and cti in the same edge; stb stays high if the burst
//   continues. No wait states are inserted by the master.
// - After the last ack of a burst: cyc=stb=0 for exactly 1 cycle (GAP).
//   Then start the next burst, or change phase.
// - WR done -> RD if op 10, else DONE. RD done -> DONE.
// - RD compare on each ack: wb_dat_i != pattern -> err_cnt++ (saturating) and err_o=1.
//   first_err_addr_o is captured only on the first mismatch.
// - ack while stb=0 is ignored.
// - Timeout: counter resets on every ack and at each burst start.
//   It reaches TO_CYCLES with stb=1 and no ack -> at the next edge cyc=stb=0,
//   timeout_o=err_o=1, go DONE.
// - DONE: done_o=1 for 1 cycle; busy_o=0 in the same cycle. Then IDLE.
//   Status stays held until the next start.
// - start_i during busy or DONE: ignored.
// - cyc/stb/we/addr/dat/sel/cti are registered outputs.
// - addr/dat/sel/cti are 0 when stb=0.
// TESTING
// 1 Reset 5 cycles, hold -> every output 0; start_i under reset -> no cyc.
// 2 op=10, pat=00, base=0, len=4, seed=0x1000, BL=8 -> writes to 0,4,8,C with data
//   0x1000..0x1003 and cti 010,010,010,111. Then 1 gap cycle, 4 matching reads, done pulse,
//   err_cnt=0.
// 3 len=20, BL=8, op=00 -> bursts of 8/8/4. cti=111 on beats 8, 16, 20.
//   cyc low exactly 1 cycle between bursts.
// 4 op=01, pat=10, base=0x100, slave flips bit0 of beat 3 -> err_cnt=1,
//   first_err_addr=0x10C, err_o=1, done pulse.
// 5 Slave never acks, TO_CYCLES=64 -> stb drops 64 cycles after rise,
//   timeout_o=1, err_o=1, done pulse.
// 6 len=0 -> done at N+1, no cyc. Base=0x3FFFFFC with len=2 -> second addr=0x0000000.
//   Reset at beat 2 of 8 -> cyc=0 next edge.

Source files
------------

// File: rtl/wb_burst_traffic_gen_if.sv
// Wishbone B3 master-side signal bundle for the burst traffic generator.
interface wb_burst_traffic_gen_if #(
  parameter int DW = 32,
  parameter int AW = 26
);
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_burst_traffic_gen.sv
// Wishbone B3 burst master: patterned write and/or read-back traffic with
// read-data checking, mismatch logging and stalled-bus timeout abort.
module wb_burst_traffic_gen #(
  parameter int DW        = 32,
  parameter int AW        = 26,
  parameter int BL        = 8,
  parameter int LENW      = 16,
  parameter int TO_CYCLES = 1024,
  parameter int ECW       = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start_i,
  input  logic [1:0]             cfg_op_i,
  input  logic [1:0]             cfg_pat_i,
  input  logic [AW-1:0]          cfg_base_i,
  input  logic [LENW-1:0]        cfg_len_i,
  input  logic [DW-1:0]          cfg_seed_i,
  wb_burst_traffic_gen_if.master wb,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   timeout_o,
  output logic [ECW-1:0]         err_cnt_o,
  output logic [AW-1:0]          first_err_addr_o
);
  localparam int BPW = DW / 8;
  localparam int BCW = $clog2(BL + 1);
  localparam int TOW = $clog2(TO_CYCLES + 1);
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} state_t;
  state_t r_state, w_state;

  logic             r_rd_phase, w_rd_phase, r_two_phase, w_two_phase;
  logic [1:0]       r_pat, w_pat;
  logic [AW-1:0]    r_base, w_base;
  logic [LENW-1:0]  r_len, w_len, r_idx, w_idx;
  logic [DW-1:0]    r_seed, w_seed;
  logic [BCW-1:0]   r_bcnt, w_bcnt;
  logic [TOW-1:0]   r_to, w_to;
  logic             r_cyc, w_cyc, r_stb, w_stb, r_we, w_we;
  logic [AW-1:0]    r_addr, w_addr;
  logic [DW-1:0]    r_dat, w_dat;
  logic [BPW-1:0]   r_sel, w_sel;
  logic [2:0]       r_cti, w_cti;
  logic             r_busy, w_busy, r_done, w_done, r_err, w_err, r_timeout, w_timeout;
  logic [ECW-1:0]   r_err_cnt, w_err_cnt;
  logic [AW-1:0]    r_fea, w_fea;
  logic             w_launch, w_clr_bus, w_ack, w_mismatch;
  logic [LENW-1:0]  w_l_idx;
  logic [BCW-1:0]   w_l_bcnt;
  logic [DW-1:0]    w_exp_rd;

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base,
                                            input logic [LENW-1:0] idx);
    return base + AW'(idx) * AW'(BPW);
  endfunction

  function automatic logic [DW-1:0] pat_of(input logic [1:0] pat, input logic [DW-1:0] seed,
                                           input logic [AW-1:0] addr, input logic [LENW-1:0] idx);
    case (pat)
      2'b00:   return seed + DW'(idx);
      2'b01:   return ~(seed + DW'(idx));
      2'b10:   return DW'(addr);
      default: return seed;
    endcase
  endfunction

  always_comb begin
    w_state = r_state;  w_rd_phase = r_rd_phase;  w_two_phase = r_two_phase;
    w_pat = r_pat;  w_base = r_base;  w_len = r_len;  w_seed = r_seed;
    w_idx = r_idx;  w_bcnt = r_bcnt;  w_to = r_to;
    w_cyc = r_cyc;  w_stb = r_stb;  w_we = r_we;  w_addr = r_addr;
    w_dat = r_dat;  w_sel = r_sel;  w_cti = r_cti;
    w_busy = r_busy;  w_done = 1'b0;  w_err = r_err;  w_timeout = r_timeout;
    w_err_cnt = r_err_cnt;  w_fea = r_fea;
    w_launch = 1'b0;  w_clr_bus = 1'b0;  w_l_idx = '0;  w_l_bcnt = '0;
    w_ack = r_stb & wb.wb_ack_i;
    w_exp_rd = pat_of(r_pat, r_seed, r_addr, r_idx);
    w_mismatch = w_ack & ~r_we & (wb.wb_dat_i != w_exp_rd);

    case (r_state)
      S_IDLE: if (start_i) begin
        w_two_phase = cfg_op_i[1];
        w_rd_phase  = (cfg_op_i == 2'b01);
        w_pat  = cfg_pat_i;
        w_base = cfg_base_i & ~AW'(BPW - 1);
        w_len  = cfg_len_i;
        w_seed = cfg_seed_i;
        w_err = 1'b0;  w_timeout = 1'b0;  w_err_cnt = '0;  w_fea = '0;
        if (cfg_len_i == '0) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else begin
          w_state  = S_BURST;
          w_busy   = 1'b1;
          w_launch = 1'b1;
        end
      end
      S_BURST: begin
        if (w_ack) begin
          if (w_mismatch) begin
            w_err = 1'b1;
            if (r_err_cnt != '1) w_err_cnt = r_err_cnt + ECW'(1);
            if (r_err_cnt == '0) w_fea = r_addr;
          end
          if (r_cti == CTI_END) begin
            w_state   = S_GAP;
            w_idx     = r_idx + LENW'(1);
            w_clr_bus = 1'b1;
          end else begin
            w_launch = 1'b1;
            w_l_idx  = r_idx + LENW'(1);
            w_l_bcnt = r_bcnt + BCW'(1);
          end
        end else if (r_to == TOW'(TO_CYCLES - 1)) begin
          // stalled slave: abandon the whole operation, not just this burst
          w_clr_bus = 1'b1;
          w_timeout = 1'b1;
          w_err     = 1'b1;
          w_state   = S_DONE;
          w_done    = 1'b1;
          w_busy    = 1'b0;
        end else begin
          w_to = r_to + TOW'(1);
        end
      end
      S_GAP: begin
        if (r_idx != r_len) begin
          w_launch = 1'b1;
          w_l_idx  = r_idx;
          w_state  = S_BURST;
        end else if (!r_rd_phase && r_two_phase) begin
          w_rd_phase = 1'b1;
          w_launch   = 1'b1;
          w_state    = S_BURST;
        end else begin
          w_state = S_DONE;
          w_done  = 1'b1;
          w_busy  = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase

    if (w_clr_bus) begin
      w_cyc = 1'b0;  w_stb = 1'b0;  w_we = 1'b0;
      w_addr = '0;  w_dat = '0;  w_sel = '0;  w_cti = '0;
    end
    // present beat w_l_idx; bursts restart at BL multiples so they stay BL-aligned to base
    if (w_launch) begin
      w_cyc  = 1'b1;  w_stb = 1'b1;  w_we = ~w_rd_phase;
      w_idx  = w_l_idx;  w_bcnt = w_l_bcnt;  w_to = '0;
      w_addr = addr_of(w_base, w_l_idx);
      w_dat  = w_we ? pat_of(w_pat, w_seed, w_addr, w_l_idx) : '0;
      w_sel  = '1;
      w_cti  = (w_l_idx == w_len - LENW'(1) || w_l_bcnt == BCW'(BL - 1)) ? CTI_END : CTI_INC;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;  r_rd_phase <= 1'b0;  r_two_phase <= 1'b0;
      r_pat <= '0;  r_base <= '0;  r_len <= '0;  r_seed <= '0;
      r_idx <= '0;  r_bcnt <= '0;  r_to <= '0;
      r_cyc <= 1'b0;  r_stb <= 1'b0;  r_we <= 1'b0;  r_addr <= '0;
      r_dat <= '0;  r_sel <= '0;  r_cti <= '0;
      r_busy <= 1'b0;  r_done <= 1'b0;  r_err <= 1'b0;  r_timeout <= 1'b0;
      r_err_cnt <= '0;  r_fea <= '0;
    end else begin
      r_state <= w_state;  r_rd_phase <= w_rd_phase;  r_two_phase <= w_two_phase;
      r_pat <= w_pat;  r_base <= w_base;  r_len <= w_len;  r_seed <= w_seed;
      r_idx <= w_idx;  r_bcnt <= w_bcnt;  r_to <= w_to;
      r_cyc <= w_cyc;  r_stb <= w_stb;  r_we <= w_we;  r_addr <= w_addr;
      r_dat <= w_dat;  r_sel <= w_sel;  r_cti <= w_cti;
      r_busy <= w_busy;  r_done <= w_done;  r_err <= w_err;  r_timeout <= w_timeout;
      r_err_cnt <= w_err_cnt;  r_fea <= w_fea;
    end
  end

  assign wb.wb_cyc_o  = r_cyc;
  assign wb.wb_stb_o  = r_stb;
  assign wb.wb_we_o   = r_we;
  assign wb.wb_addr_o = r_addr;
  assign wb.wb_dat_o  = r_dat;
  assign wb.wb_sel_o  = r_sel;
  assign wb.wb_cti_o  = r_cti;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign err_o            = r_err;
  assign timeout_o        = r_timeout;
  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_fea;
endmodule

// File: tb/tb_wb_burst_traffic_gen.sv
// Directed bench: expected beat list built from the pattern/burst rules, a
// zero-wait slave with optional data corruption, and a per-cycle compare process.
module tb_wb_burst_traffic_gen;
  localparam int DW = 32, AW = 26, BL = 8, LENW = 16, TO = 64, ECW = 16;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic [1:0]      op = '0, pat = '0;
  logic [AW-1:0]   base = '0;
  logic [LENW-1:0] len = '0;
  logic [DW-1:0]   seed = '0;
  logic            d_busy, d_done, d_err, d_tmo;
  logic [ECW-1:0]  d_ecnt;
  logic [AW-1:0]   d_fea;

  wb_burst_traffic_gen_if #(.DW(DW), .AW(AW)) bus ();

  wb_burst_traffic_gen #(.DW(DW), .AW(AW), .BL(BL), .LENW(LENW), .TO_CYCLES(TO), .ECW(ECW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .cfg_op_i(op), .cfg_pat_i(pat),
    .cfg_base_i(base), .cfg_len_i(len), .cfg_seed_i(seed), .wb(bus.master),
    .busy_o(d_busy), .done_o(d_done), .err_o(d_err), .timeout_o(d_tmo),
    .err_cnt_o(d_ecnt), .first_err_addr_o(d_fea)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic [2:0]    cti;
  } beat_t;
  beat_t exp_q[$];

  int n_chk = 0, n_err = 0;
  bit mon_on = 0, op_active = 0, ack_en = 1, have_prev = 0, prev_last = 0;
  int flip_idx = -1, rd_n = 0, gap_cnt = 0, stb_hi = 0, op_cyc = 0, last_done_cyc = 0;
  int exp_errs = 0;
  logic [AW-1:0] exp_fea = '0;
  bit exp_err = 0, exp_to = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] mpat(input logic [1:0] p, input logic [DW-1:0] s,
                                         input logic [AW-1:0] a, input int i);
    case (p)
      2'd0:    return s + DW'(i);
      2'd1:    return ~(s + DW'(i));
      2'd2:    return DW'(a);
      default: return s;
    endcase
  endfunction

  // Every beat the op must issue, in order, for its write and/or read phase.
  task automatic build(input logic [1:0] o, input logic [1:0] p, input logic [AW-1:0] b,
                       input int l, input logic [DW-1:0] s);
    logic [AW-1:0] a0;
    int nph;
    beat_t e;
    exp_q.delete();
    a0 = b & ~AW'(3);
    nph = (o == 2'd0 || o == 2'd1) ? 1 : 2;
    for (int ph = 0; ph < nph; ph++)
      for (int i = 0; i < l; i++) begin
        e.we   = (o != 2'd1) && (ph == 0);
        e.addr = a0 + AW'(4 * i);
        e.dat  = mpat(p, s, e.addr, i);
        e.cti  = ((i % BL) == BL - 1 || i == l - 1) ? 3'b111 : 3'b010;
        exp_q.push_back(e);
      end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!mon_on || rst) begin
      bus.wb_ack_i = 1'b0;
      bus.wb_dat_i = '0;
    end else begin
      if (bus.wb_stb_o) begin
        chk("cyc_with_stb", 64'(bus.wb_cyc_o), 64'd1);
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL extra_beat: got beat at addr 0x%0h, required none", bus.wb_addr_o);
          bus.wb_ack_i = 1'b0;
        end else begin
          e = exp_q[0];
          chk("beat_we", 64'(bus.wb_we_o), 64'(e.we));
          chk("beat_addr", 64'(bus.wb_addr_o), 64'(e.addr));
          chk("beat_sel", 64'(bus.wb_sel_o), 64'hF);
          chk("beat_cti", 64'(bus.wb_cti_o), 64'(e.cti));
          if (e.we) chk("beat_wdat", 64'(bus.wb_dat_o), 64'(e.dat));
          if (have_prev) begin
            chk("gap_cycles", 64'(gap_cnt), prev_last ? 64'd1 : 64'd0);
            have_prev = 0;
          end
          stb_hi++;
          if (ack_en) begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = e.we ? '0 : (e.dat ^ ((rd_n == flip_idx) ? DW'(1) : DW'(0)));
            if (!e.we) rd_n++;
            void'(exp_q.pop_front());
            have_prev = 1; prev_last = (e.cti == 3'b111); gap_cnt = 0;
          end else begin
            bus.wb_ack_i = 1'b0;
          end
        end
      end else begin
        chk("idle_cyc", 64'(bus.wb_cyc_o), 64'd0);
        chk("idle_addr", 64'(bus.wb_addr_o), 64'd0);
        chk("idle_dat", 64'(bus.wb_dat_o), 64'd0);
        chk("idle_sel", 64'(bus.wb_sel_o), 64'd0);
        chk("idle_cti", 64'(bus.wb_cti_o), 64'd0);
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = '0;
        if (op_active) gap_cnt++;
      end
      if (op_active) begin
        op_cyc++;
        if (d_done) begin
          chk("busy_at_done", 64'(d_busy), 64'd0);
          if (exp_to) chk("stb_high_cycles", 64'(stb_hi), 64'(TO));
          else        chk("beats_left", 64'(exp_q.size()), 64'd0);
          chk("err_cnt", 64'(d_ecnt), 64'(exp_errs));
          chk("first_err_addr", 64'(d_fea), 64'(exp_fea));
          chk("err_o", 64'(d_err), 64'(exp_err));
          chk("timeout_o", 64'(d_tmo), 64'(exp_to));
          last_done_cyc = op_cyc;
          op_active = 0;
        end else begin
          chk("busy_in_op", 64'(d_busy), 64'd1);
        end
      end else begin
        chk("idle_done", 64'(d_done), 64'd0);
        chk("idle_busy", 64'(d_busy), 64'd0);
      end
    end
  end

  task automatic do_start(input logic [1:0] o, input logic [1:0] p, input logic [AW-1:0] b,
                          input int l, input logic [DW-1:0] s);
    rd_n = 0; have_prev = 0; gap_cnt = 0; stb_hi = 0; op_cyc = 0;
    @(posedge clk); #1;
    start = 1'b1; op = o; pat = p; base = b; len = LENW'(l); seed = s;
    @(posedge clk); #1;
    start = 1'b0; op_active = 1;
    op = ~o; pat = ~p; base = ~b; len = '1; seed = ~s;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [1:0] p, input logic [AW-1:0] b,
                        input int l, input logic [DW-1:0] s, input int budget, input bit poke);
    do_start(o, p, b, l, s);
    for (int c = 0; c < budget && op_active; c++) begin
      @(posedge clk);
      if (poke && c == 5) begin
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    if (op_active) begin
      n_chk++; n_err++;
      $display("FAIL op_done_wait: got no done_o within %0d cycles, required done", budget);
      op_active = 0;
    end
    @(negedge clk);
    chk("done_one_cycle", 64'(d_done), 64'd0);
    chk("held_err_cnt", 64'(d_ecnt), 64'(exp_errs));
    chk("held_err", 64'(d_err), 64'(exp_err));
    chk("held_timeout", 64'(d_tmo), 64'(exp_to));
  endtask

  initial begin
    int n7;
    // reset held with a start pulse pending
    start = 1'b1; op = 2'd2; len = 16'd4;
    repeat (5) begin
      @(negedge clk);
      chk("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
      chk("rst_stb", 64'(bus.wb_stb_o), 64'd0);
      chk("rst_addr", 64'(bus.wb_addr_o), 64'd0);
      chk("rst_busy", 64'(d_busy), 64'd0);
      chk("rst_done", 64'(d_done), 64'd0);
      chk("rst_status", 64'({d_err, d_tmo, d_ecnt, d_fea}), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    end
    mon_on = 1;

    // write then read, 4 words
    build(2'd2, 2'd0, '0, 4, 32'h1000);
    chk("m2_size", 64'(exp_q.size()), 64'd8);
    chk("m2_addr1", 64'(exp_q[1].addr), 64'h4);
    chk("m2_dat3", 64'(exp_q[3].dat), 64'h1003);
    chk("m2_cti2", 64'(exp_q[2].cti), 64'h2);
    chk("m2_cti3", 64'(exp_q[3].cti), 64'h7);
    chk("m2_rd0", 64'({exp_q[4].we, exp_q[4].addr}), 64'h0);
    exp_errs = 0; exp_fea = '0; exp_err = 0; exp_to = 0;
    run_op(2'd2, 2'd0, '0, 4, 32'h1000, 200, 0);

    // 20-word write: bursts 8/8/4, start pulse while busy is ignored
    build(2'd0, 2'd1, 26'h40, 20, 32'hFFFF_FFF0);
    n7 = 0;
    foreach (exp_q[k]) if (exp_q[k].cti == 3'b111) n7++;
    chk("m3_n_last", 64'(n7), 64'd3);
    chk("m3_last", 64'({exp_q[7].cti, exp_q[15].cti, exp_q[19].cti}), 64'h1FF);
    chk("m3_dat16", 64'(exp_q[16].dat), 64'hFFFF_FFFF);
    run_op(2'd0, 2'd1, 26'h40, 20, 32'hFFFF_FFF0, 300, 1);

    // read-only address pattern, slave corrupts beat 3
    build(2'd1, 2'd2, 26'h100, 8, '0);
    chk("m4_addr3", 64'(exp_q[3].addr), 64'h10C);
    chk("m4_dat3", 64'(exp_q[3].dat), 64'h10C);
    flip_idx = 3; exp_errs = 1; exp_fea = 26'h10C; exp_err = 1; exp_to = 0;
    run_op(2'd1, 2'd2, 26'h100, 8, '0, 200, 0);
    flip_idx = -1;

    // slave never acks
    build(2'd0, 2'd0, 26'h200, 4, '0);
    ack_en = 0; exp_errs = 0; exp_fea = '0; exp_err = 1; exp_to = 1;
    run_op(2'd0, 2'd0, 26'h200, 4, '0, 300, 0);
    ack_en = 1; exp_err = 0; exp_to = 0;

    // zero length: done one cycle after start, no bus activity
    build(2'd2, 2'd0, '0, 0, '0);
    run_op(2'd2, 2'd0, '0, 0, '0, 20, 0);
    chk("len0_latency", 64'(last_done_cyc), 64'd1);

    // address wrap at the top of the space
    build(2'd0, 2'd3, 26'h3FF_FFFC, 2, 32'hA5A5_A5A5);
    chk("m6_wrap", 64'(exp_q[1].addr), 64'h0);
    run_op(2'd0, 2'd3, 26'h3FF_FFFC, 2, 32'hA5A5_A5A5, 100, 0);

    // reserved op behaves as write-then-read; unaligned base; trailing 1-beat burst
    build(2'd3, 2'd0, 26'h13, 9, 32'h77);
    chk("m6_size", 64'(exp_q.size()), 64'd18);
    chk("m6_base", 64'(exp_q[0].addr), 64'h10);
    chk("m6_cti78", 64'({exp_q[7].cti, exp_q[8].cti}), 64'h3F);
    run_op(2'd3, 2'd0, 26'h13, 9, 32'h77, 300, 0);

    // reset in the middle of an 8-beat burst
    build(2'd0, 2'd0, '0, 8, '0);
    do_start(2'd0, 2'd0, '0, 8, '0);
    for (int c = 0; c < 50 && exp_q.size() > 5; c++) @(posedge clk);
    #1 rst = 1'b1; mon_on = 0; op_active = 0;
    @(negedge clk);
    chk("cyc_before_reset", 64'(bus.wb_cyc_o), 64'd1);
    @(negedge clk);
    chk("cyc_after_reset", 64'(bus.wb_cyc_o), 64'd0);
    chk("stb_after_reset", 64'(bus.wb_stb_o), 64'd0);
    chk("addr_after_reset", 64'(bus.wb_addr_o), 64'd0);
    chk("busy_after_reset", 64'(d_busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; exp_q.delete(); mon_on = 1;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
